// File: rtl/reg_four_bit_adder.sv
// ---------------------------------------------------------------------------
// reg_four_bit_adder
//
// Registered unsigned adder. Two WIDTH-bit operands are summed through a
// ripple-carry chain of full-adder cells. The WIDTH+1-bit result, including
// the carry-out, is captured in an output register on every rising clock edge.
// There is no enable and no handshake. Carry-in is fixed at zero.
//
// Ports:
//   clk   in   1         system clock; state updates on the rising edge
//   rstn  in   1         asynchronous active-low reset; clears c immediately
//   a     in   WIDTH     operand A, unsigned
//   b     in   WIDTH     operand B, unsigned
//   c     out  WIDTH+1   registered sum; c[WIDTH] is the carry-out
// ---------------------------------------------------------------------------
module reg_four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   c
);

  // w_k[i] is the carry into cell i. w_k[WIDTH] is the carry-out.
  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_next_sum;
  logic [WIDTH:0]   r_sum;

  assign w_k[0] = 1'b0;

  // One full-adder cell per bit, chained from LSB to MSB.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic w_p;  // propagate term, reused for sum and carry
      assign w_p         = a[gi] ^ b[gi];
      assign w_s[gi]     = w_p ^ w_k[gi];
      assign w_k[gi + 1] = (a[gi] & b[gi]) | (w_k[gi] & w_p);
    end
  endgenerate

  assign w_next_sum = {w_k[WIDTH], w_s};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_next_sum;
    end
  end

  assign c = r_sum;

endmodule

// File: tb/tb_reg_four_bit_adder.sv
// ---------------------------------------------------------------------------
// tb_reg_four_bit_adder
//
// Directed and random stimulus for reg_four_bit_adder. Expected sums are
// pushed to a queue when operands are driven. They are popped and compared
// after the capturing edge. Reset behaviour is checked against zero.
// ---------------------------------------------------------------------------
module tb_reg_four_bit_adder;

  logic       clk;
  logic       rstn;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] c;

  int total;
  int bad;

  logic [4:0] sb_q[$];

  reg_four_bit_adder #(.WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .a    (a),
    .b    (b),
    .c    (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: c=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Pop one expected sum and compare it just after the capturing edge.
  task automatic check_pop(input string tag);
    logic [4:0] exp;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, c=%b", tag, c);
    end else begin
      exp = sb_q.pop_front();
      compare(tag, c, exp);
    end
    $display("txn %s: a=%b b=%b c=%b", tag, a, b, c);
  endtask

  // Drive operands at a falling edge, push the expected sum, and check it
  // after the next rising edge. Return at the following falling edge.
  task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic [4:0] exp);
    a = va;
    b = vb;
    sb_q.push_back(exp);
    check_pop(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    total = 0;
    bad   = 0;

    // Power-up: reset asserted with unknown operands.
    rstn = 1'b1;
    a    = 'x;
    b    = 'x;
    #1;
    rstn = 1'b0;
    #1;
    compare("por_immediate", c, 5'b00000);
    repeat (2) begin
      @(posedge clk);
      #1;
      compare("por_hold", c, 5'b00000);
    end

    // Release reset and run the directed sums.
    @(negedge clk);
    rstn = 1'b1;
    apply("zero_0",   4'b0000, 4'b0000, 5'b00000);
    apply("zero_1",   4'b0000, 4'b0000, 5'b00000);
    apply("no_carry", 4'b1010, 4'b0101, 5'b01111);
    apply("carry",    4'b1010, 4'b1100, 5'b10110);

    // Reset mid-operation while c holds 10110.
    #1;
    rstn = 1'b0;
    a    = 4'b0010;
    b    = 4'b1000;
    #1;
    compare("mid_rst_immediate", c, 5'b00000);
    repeat (2) begin
      @(posedge clk);
      #1;
      compare("mid_rst_hold", c, 5'b00000);
    end
    @(negedge clk);
    rstn = 1'b1;
    sb_q.push_back(5'b01010);
    check_pop("rst_release");
    @(negedge clk);

    // Boundary cases: full ripple through all cells.
    apply("max_max", 4'b1111, 4'b1111, 5'b11110);
    apply("ripple",  4'b1111, 4'b0001, 5'b10000);

    // Back-to-back random operands.
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      apply("random", ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
